vector_alu_sequencer: RTL and testbench

Multi-cycle controller for the vector path of the execute stage. It takes one 128-bit vector operation from the DecodeExecute pipeline register and splits it into beats of four 8-bit lanes. Each beat goes to a narrow lane-slice ALU, and the lane results are collected into a 128-bit result. While the operation is in flight the block holds the front of the pipeline with `stall`, then presents the full result for one cycle to the ExecuteMemory register.

---
 rtl/vector_alu_sequencer_pkg.sv | 35 +++
 rtl/vector_alu_sequencer_if.sv | 45 ++++
 rtl/vector_alu_sequencer.sv | 139 +++++++++++++
 tb/tb_vector_alu_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vector_alu_sequencer_pkg.sv
// Purpose : shared constants, types and helpers for the vector ALU sequencer.
// Latency : n/a (declarations only).
// Backpr. : n/a (declarations only).
package vector_alu_sequencer_pkg;

    // Vector geometry: 16 lanes of 8 bits, processed four lanes per beat.
    localparam int LANE_W         = 8;
    localparam int LANES_PER_BEAT = 4;
    localparam int NUM_LANES      = 16;
    localparam int BEATS          = NUM_LANES / LANES_PER_BEAT;

    localparam int BEAT_W     = LANE_W * LANES_PER_BEAT;   // one lane-slice word
    localparam int VEC_W      = LANE_W * NUM_LANES;        // whole vector
    localparam int BEAT_IDX_W = $clog2(BEATS);
    localparam int OP_W       = 5;

    localparam logic [OP_W-1:0] VEC_OP_NOP = 5'b00000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } vec_seq_state_t;

    typedef logic [BEAT_IDX_W-1:0] beat_idx_t;
    typedef logic [OP_W-1:0]       vec_op_t;
    typedef logic [VEC_W-1:0]      vec_dat_t;
    typedef logic [BEAT_W-1:0]     beat_dat_t;

    // Select the 32-bit slice of a vector that belongs to a given beat.
    function automatic beat_dat_t beat_slice(input vec_dat_t vec, input beat_idx_t beat);
        return vec[int'(beat) * BEAT_W +: BEAT_W];
    endfunction

endpackage

// File: rtl/vector_alu_sequencer_if.sv
// Purpose : bundles the execute-stage vector op, the lane-slice ALU link and
//           the result/stall signals of the vector ALU sequencer.
// Latency : n/a (wiring only).
// Backpr. : stall is the only hold signal; it travels sequencer -> pipeline front.
//
// Modports
//   master : pipeline + lane-slice ALU side (drives op/operands/flush/lane_result)
//   slave  : sequencer side (drives lane_* operands, result, stall, busy)
interface vector_alu_sequencer_if;
    import vector_alu_sequencer_pkg::*;

    // Op from the DecodeExecute register (operands already forwarded).
    logic      vec_start;
    logic      flush;
    vec_op_t   aluVectorOp_execute;
    vec_dat_t  srcA_vector;
    vec_dat_t  srcB_vector;

    // Link to the lane-slice ALU.
    vec_op_t   lane_op;
    beat_dat_t lane_srcA;
    beat_dat_t lane_srcB;
    beat_dat_t lane_result;

    // Towards ExecuteMemory and the pipeline front.
    vec_dat_t  result_vector;
    logic      result_valid;
    logic      stall;
    logic      busy;

    modport master (
        output vec_start, flush, aluVectorOp_execute, srcA_vector, srcB_vector,
        output lane_result,
        input  lane_op, lane_srcA, lane_srcB,
        input  result_vector, result_valid, stall, busy
    );

    modport slave (
        input  vec_start, flush, aluVectorOp_execute, srcA_vector, srcB_vector,
        input  lane_result,
        output lane_op, lane_srcA, lane_srcB,
        output result_vector, result_valid, stall, busy
    );

endinterface

// File: rtl/vector_alu_sequencer.sv
// Purpose : splits one 128-bit vector op into four 32-bit beats for the lane-slice ALU
//           and reassembles the 128-bit result.
// Latency : 5 cycles accept -> result_valid; 5-cycle throughput back-to-back.
// Backpr. : stall held in the accept cycle and every BUSY cycle; no stall in DONE.
//
// Ports
//   clk, reset : single clock, synchronous active-high reset
//   vif        : slave side of vector_alu_sequencer_if (op in, lane link, result out)
module vector_alu_sequencer
    import vector_alu_sequencer_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    vector_alu_sequencer_if.slave  vif
);

    vec_seq_state_t state_q, state_d;
    beat_idx_t      beat_q;
    vec_op_t        op_q;
    vec_dat_t       src_a_q;
    vec_dat_t       src_b_q;
    vec_dat_t       result_q;

    logic accept;
    logic last_beat;
    logic beat_wr;

    // An op is taken only from IDLE/DONE; reset and flush both veto it.
    always_comb begin
        accept = 1'b0;
        if (!reset && !vif.flush && vif.vec_start &&
            (vif.aluVectorOp_execute != VEC_OP_NOP) &&
            ((state_q == IDLE) || (state_q == DONE))) begin
            accept = 1'b1;
        end
    end

    assign last_beat = (beat_q == beat_idx_t'(BEATS - 1));

    // A flushed BUSY cycle does not write its beat; earlier beats stay put.
    assign beat_wr = (state_q == BUSY) && !vif.flush;

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (vif.flush) begin
                    state_d = IDLE;
                end else if (last_beat) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // Result is already complete, so a flush here only blocks the
                // next accept; it does not cancel result_valid.
                state_d = accept ? BUSY : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs. Everything is forced quiet while reset is asserted so the
    // pipeline never sees a stall or result from the op being discarded.
    always_comb begin
        vif.lane_op       = VEC_OP_NOP;
        vif.lane_srcA     = '0;
        vif.lane_srcB     = '0;
        vif.stall         = 1'b0;
        vif.busy          = 1'b0;
        vif.result_valid  = 1'b0;
        vif.result_vector = result_q;

        if (!reset) begin
            vif.busy = (state_q != IDLE);

            case (state_q)
                IDLE: begin
                    vif.stall = accept;
                end
                BUSY: begin
                    vif.lane_op   = op_q;
                    vif.lane_srcA = beat_slice(src_a_q, beat_q);
                    vif.lane_srcB = beat_slice(src_b_q, beat_q);
                    // Releasing stall in the flush cycle lets the front of the
                    // pipeline refetch immediately.
                    vif.stall     = !vif.flush;
                end
                DONE: begin
                    // Stall stays low even when the next op is accepted: this
                    // is the single cycle where DecodeExecute and
                    // ExecuteMemory both advance.
                    vif.result_valid = 1'b1;
                end
                default: begin
                    vif.stall = 1'b0;
                end
            endcase
        end
    end

    // State, beat counter, operand latches and result assembly.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            beat_q   <= '0;
            op_q     <= VEC_OP_NOP;
            src_a_q  <= '0;
            src_b_q  <= '0;
            result_q <= '0;
        end else begin
            state_q <= state_d;

            if (accept) begin
                op_q    <= vif.aluVectorOp_execute;
                src_a_q <= vif.srcA_vector;
                src_b_q <= vif.srcB_vector;
                beat_q  <= '0;
            end else if ((state_q == BUSY) && vif.flush) begin
                beat_q <= '0;
            end else if (state_q == BUSY) begin
                // Wraps to 0 after the last beat, ready for the next op.
                beat_q <= beat_q + beat_idx_t'(1);
            end

            if (beat_wr) begin
                result_q[int'(beat_q) * BEAT_W +: BEAT_W] <= vif.lane_result;
            end
        end
    end

endmodule

// File: tb/tb_vector_alu_sequencer.sv
module tb_vector_alu_sequencer;

    logic clk;
    logic reset;

    vector_alu_sequencer_if vif ();

    vector_alu_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .vif   (vif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- reference behaviour ----------------
    // Lane ALU opcodes used by this bench: 1 add, 2 sub, 3 xor, 4 and, other or.
    function automatic logic [7:0] lane_fn(input logic [4:0] op, input logic [7:0] x,
                                           input logic [7:0] y);
        case (op)
            5'd1:    return x + y;
            5'd2:    return x - y;
            5'd3:    return x ^ y;
            5'd4:    return x & y;
            default: return x | y;
        endcase
    endfunction

    function automatic logic [127:0] vec_model(input logic [4:0] op, input logic [127:0] a,
                                               input logic [127:0] b);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[i*8 +: 8] = lane_fn(op, a[i*8 +: 8], b[i*8 +: 8]);
        return r;
    endfunction

    // Stand-in for the sibling lane-slice ALU: four combinational 8-bit lanes.
    always_comb begin
        vif.lane_result = '0;
        for (int i = 0; i < 4; i++)
            vif.lane_result[i*8 +: 8] = lane_fn(vif.lane_op, vif.lane_srcA[i*8 +: 8],
                                                vif.lane_srcB[i*8 +: 8]);
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Inputs change 1ns after the rising edge, outputs are sampled at 2ns.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [4:0] op, input logic [127:0] a, input logic [127:0] b);
        vif.vec_start           = 1'b1;
        vif.aluVectorOp_execute = op;
        vif.srcA_vector         = a;
        vif.srcB_vector         = b;
    endtask

    task automatic idle_inputs();
        vif.vec_start           = 1'b0;
        vif.aluVectorOp_execute = 5'd0;
        vif.flush               = 1'b0;
    endtask

    // Presents one op, then watches a bounded window for its result.
    // lat counts cycles after the accept edge; -1 if result_valid never came.
    task automatic run_op(input logic [4:0] op, input logic [127:0] a, input logic [127:0] b,
                          output logic [127:0] res, output int lat, output int stalls);
        res    = '0;
        lat    = -1;
        stalls = 0;
        present(op, a, b);
        #1;
        if (vif.stall) stalls++;
        next_cycle();
        idle_inputs();
        for (int c = 1; c <= 10; c++) begin
            #1;
            if (vif.stall) stalls++;
            if (vif.result_valid && lat < 0) begin
                lat = c;
                res = vif.result_vector;
            end
            next_cycle();
        end
    endtask

    typedef struct {
        string        name;
        logic [4:0]   op;
        logic [127:0] a;
        logic [127:0] b;
        logic [127:0] exp;
    } vec_t;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t         tbl[6];
        logic [127:0] res, r1, r2, exp_v, a, b, slice_a;
        logic [31:0]  exp_slice[4];
        int           lat, stalls, cnt, first_v, second_v, low;
        logic [4:0]   op;

        slice_a = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
        exp_slice[0] = 32'h03020100;
        exp_slice[1] = 32'h07060504;
        exp_slice[2] = 32'h0B0A0908;
        exp_slice[3] = 32'h0F0E0D0C;

        tbl[0] = '{"add01_02", 5'd1, {16{8'h01}}, {16{8'h02}}, {16{8'h03}}};
        tbl[1] = '{"add10_01", 5'd1, {16{8'h10}}, {16{8'h01}}, {16{8'h11}}};
        tbl[2] = '{"sub05_07", 5'd2, {16{8'h05}}, {16{8'h07}}, {16{8'hFE}}};
        tbl[3] = '{"xor_ramp", 5'd3, slice_a, {16{8'hFF}},
                   128'hF0F1F2F3_F4F5F6F7_F8F9FAFB_FCFDFEFF};
        tbl[4] = '{"and_f0_3c", 5'd4, {16{8'hF0}}, {16{8'h3C}}, {16{8'h30}}};
        tbl[5] = '{"or_mix", 5'd9, {8{16'h00FF}}, {16{8'h0F}}, {8{16'h0FFF}}};

        // ---------------- reset state ----------------
        reset                   = 1'b1;
        vif.vec_start           = 1'b0;
        vif.flush               = 1'b0;
        vif.aluVectorOp_execute = 5'd0;
        vif.srcA_vector         = '0;
        vif.srcB_vector         = '0;
        repeat (3) next_cycle();
        reset = 1'b0;
        #1;
        check("rst_stall", vif.stall, 0);
        check("rst_busy", vif.busy, 0);
        check("rst_valid", vif.result_valid, 0);
        check("rst_result", vif.result_vector, 0);
        check("rst_lane_op", vif.lane_op, 0);
        check("rst_lane_srcA", vif.lane_srcA, 0);
        next_cycle();

        // ---------------- table-driven single ops ----------------
        for (int i = 0; i < 6; i++) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, res, lat, stalls);
            check({"tbl_res_", tbl[i].name}, res, tbl[i].exp);
            check({"tbl_lat_", tbl[i].name}, lat, 5);
            check({"tbl_stall_", tbl[i].name}, stalls, 5);
        end

        // ---------------- beat slicing ----------------
        present(5'd1, slice_a, {16{8'h02}});
        #1;
        check("slice_accept_stall", vif.stall, 1);
        check("slice_accept_lane_op", vif.lane_op, 0);
        next_cycle();
        idle_inputs();
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("slice_srcA_b%0d", k), vif.lane_srcA, exp_slice[k]);
            check($sformatf("slice_srcB_b%0d", k), vif.lane_srcB, 32'h02020202);
            check($sformatf("slice_op_b%0d", k), vif.lane_op, 5'd1);
            check($sformatf("slice_stall_b%0d", k), vif.stall, 1);
            next_cycle();
        end
        #1;
        check("slice_valid", vif.result_valid, 1);
        check("slice_done_stall", vif.stall, 0);
        check("slice_done_busy", vif.busy, 1);
        check("slice_done_srcA", vif.lane_srcA, 0);
        check("slice_result", vif.result_vector, vec_model(5'd1, slice_a, {16{8'h02}}));
        next_cycle();
        #1;
        check("slice_after_busy", vif.busy, 0);
        check("slice_after_valid", vif.result_valid, 0);
        next_cycle();

        // ---------------- NOP ----------------
        present(5'd0, {16{8'h55}}, {16{8'h66}});
        #1;
        check("nop_stall", vif.stall, 0);
        next_cycle();
        idle_inputs();
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (vif.busy || vif.result_valid || vif.stall) cnt++;
            next_cycle();
        end
        check("nop_no_activity", cnt, 0);

        // ---------------- back-to-back ----------------
        present(5'd1, {16{8'h01}}, {16{8'h02}});
        next_cycle();
        idle_inputs();
        first_v  = -1;
        second_v = -1;
        low      = 0;
        r1       = '0;
        r2       = '0;
        for (int c = 1; c <= 13; c++) begin
            if (c == 5) present(5'd1, {16{8'h10}}, {16{8'h01}});
            #1;
            if (vif.result_valid) begin
                if (first_v < 0) begin
                    first_v = c;
                    r1      = vif.result_vector;
                end else if (second_v < 0) begin
                    second_v = c;
                    r2       = vif.result_vector;
                end
            end
            if (c <= 9 && !vif.stall) low++;
            next_cycle();
            if (c == 5) idle_inputs();
        end
        check("b2b_first_at", first_v, 5);
        check("b2b_second_at", second_v, 10);
        check("b2b_stall_low_cycles", low, 1);
        check("b2b_first_res", r1, {16{8'h03}});
        check("b2b_second_res", r2, {16{8'h11}});

        // ---------------- flush in BUSY at beat 2 ----------------
        a = {$urandom(), $urandom(), $urandom(), $urandom()};
        b = {$urandom(), $urandom(), $urandom(), $urandom()};
        exp_v = vec_model(5'd3, a, b);
        present(5'd3, a, b);
        next_cycle();
        idle_inputs();
        next_cycle();           // beat 0 written
        next_cycle();           // beat 1 written
        vif.flush = 1'b1;       // beat 2 cycle
        #1;
        check("flush_busy_stall", vif.stall, 0);
        check("flush_busy_srcA", vif.lane_srcA, a[95:64]);
        next_cycle();
        vif.flush = 1'b0;
        #1;
        check("flush_busy_idle", vif.busy, 0);
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) #1;
            if (vif.result_valid) cnt++;
            next_cycle();
        end
        check("flush_busy_no_valid", cnt, 0);
        check("flush_busy_low", vif.result_vector[63:0], exp_v[63:0]);
        check("flush_busy_high", vif.result_vector[127:64], {8{8'h11}});

        // ---------------- flush in DONE ----------------
        present(5'd2, {16{8'h09}}, {16{8'h04}});
        next_cycle();
        idle_inputs();
        repeat (4) next_cycle();
        vif.flush = 1'b1;
        present(5'd1, {16{8'h01}}, {16{8'h01}});
        #1;
        check("flush_done_valid", vif.result_valid, 1);
        check("flush_done_res", vif.result_vector, {16{8'h05}});
        check("flush_done_stall", vif.stall, 0);
        next_cycle();
        #1;
        check("flush_done_not_accepted", vif.busy, 0);
        check("flush_idle_stall", vif.stall, 0);   // flush + op still held in IDLE
        next_cycle();
        #1;
        check("flush_idle_not_accepted", vif.busy, 0);
        idle_inputs();
        next_cycle();

        // ---------------- reset mid-BUSY ----------------
        present(5'd1, {16{8'h22}}, {16{8'h11}});
        next_cycle();
        idle_inputs();
        next_cycle();
        reset = 1'b1;
        #1;
        check("rst_mid_stall", vif.stall, 0);
        check("rst_mid_valid", vif.result_valid, 0);
        next_cycle();
        next_cycle();
        reset = 1'b0;
        #1;
        check("rst_mid_busy", vif.busy, 0);
        check("rst_mid_result", vif.result_vector, 0);
        check("rst_mid_lane_op", vif.lane_op, 0);
        cnt = 0;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) #1;
            if (vif.result_valid || vif.stall) cnt++;
            next_cycle();
        end
        check("rst_mid_no_valid", cnt, 0);

        // ---------------- randomized ops vs model ----------------
        for (int i = 0; i < 24; i++) begin
            op = 5'($urandom_range(1, 6));
            a  = {$urandom(), $urandom(), $urandom(), $urandom()};
            b  = {$urandom(), $urandom(), $urandom(), $urandom()};
            run_op(op, a, b, res, lat, stalls);
            check($sformatf("rnd_res_%0d", i), res, vec_model(op, a, b));
            check($sformatf("rnd_lat_%0d", i), lat, 5);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
